chunk_sample_router: RTL and testbench
======================================

Name: chunk_sample_router

Overview:
Single-clock successor to the DRAM audio read path's chunk demux/unstacker stage. It accepts tagged DRAM read chunks (address plus packed sample data) and decodes the address against per-instrument address ranges. Each chunk is buffered in a per-channel chunk queue and serialised into per-channel sample streams for the sample mixer. New relative to the previous stage: generic width, depth and channel count; a per-channel chunk queue; per-channel flush for voice retrigger; and a configurable drop-or-stall policy for unmatched addresses with a drop counter.

Parameters:
CHANNELS, 8, number of instrument channels (>=1)
ADDR_W, 24, chunk address tag width
DATA_W, 128, chunk payload width; must be an integer multiple of SAMPLE_W
SAMPLE_W, 16, output sample width
CHUNK_DEPTH, 2, chunks buffered per channel (>=1)
DROP_UNMATCHED, 1, 1 = discard chunks matching no channel; 0 = stall on them (legacy behaviour)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr_offsets  in  (CHANNELS+1)*ADDR_W  range bounds; channel i owns [off[i], off[i+1]), with off[i] at bits i*ADDR_W +: ADDR_W
offsets_valid  in  1  bounds are valid; while low, no chunk matches any channel
chunk_tvalid  in  1  chunk valid
chunk_tready  out  1  chunk accepted when valid and ready
chunk_tdata  in  ADDR_W+DATA_W  {addr[ADDR_W-1:0], payload[DATA_W-1:0]}
ch_flush  in  CHANNELS  per-channel synchronous flush pulse
sample_tvalid  out  CHANNELS  per-channel sample valid
sample_tready  in  CHANNELS  per-channel sample ready
sample_tdata  out  CHANNELS*SAMPLE_W  channel i sample at bits i*SAMPLE_W +: SAMPLE_W
drop_count  out  16  count of discarded unmatched chunks, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all queues empty; sample indices = 0; sample_tvalid = 0; sample_tdata = 0; drop_count = 0; chunk_tready = 0 while in reset.
- Decode (combinational on chunk_tdata): match[i] = offsets_valid && addr >= off[i] && addr < off[i+1], unsigned compare. If off[i+1] <= off[i], channel i's range is empty. If ranges overlap, the lowest matching index wins (priority encode).
- chunk_tready:
  - Matched chunk: ready = target queue not full, or target ch_flush asserted this cycle.
  - Unmatched chunk with DROP_UNMATCHED=1: ready = 1; on accept, drop_count increments and saturates at 16'hFFFF.
  - Unmatched chunk with DROP_UNMATCHED=0: ready = 0, so the input stalls.
  - chunk_tready never depends combinationally on sample_tready.
- Per-channel queue: circular buffer of CHUNK_DEPTH payloads with wrapping read/write pointers and an occupancy count 0..CHUNK_DEPTH. Full = count==CHUNK_DEPTH. A simultaneous push and pop with the queue full is allowed only through the flush path; a normal push when full is impossible because ready is low.
- Serialiser per channel: SPC = DATA_W/SAMPLE_W samples per chunk.
  - sample_tdata[i] = head_payload[idx*SAMPLE_W +: SAMPLE_W], where idx starts at 0 (LSB sample first).
  - sample_tvalid[i] = queue not empty.
  - On tvalid&&tready: if idx==SPC-1, idx returns to 0 and the head is popped in the same cycle; otherwise idx increments.
  - The next chunk's sample 0 is presented the following cycle with no bubble, so back-to-back chunks sustain 1 sample/cycle.
- Latency: chunk accepted in cycle N -> its sample 0 is valid in cycle N+1 if the queue was empty. Output must be registered or read from registered storage, not a combinational pass-through of chunk_tdata.
- AXIS rules: while tvalid && !tready, sample_tdata and tvalid hold stable. tvalid never drops without a handshake, except on flush or reset.
- Flush: ch_flush[i] in cycle N empties queue i and sets idx=0 at the clock edge; sample_tvalid[i]=0 in N+1 unless a chunk for channel i was accepted in N. A same-cycle accept is written into the freshly emptied queue (flush first, then push), and its sample 0 is valid in N+1. A same-cycle output handshake in N is legal and is simply superseded.
- Channels are independent: a full or stalled channel blocks the input only when the head chunk targets it (head-of-line blocking is accepted by design).

Test Plan:
- Bounds [0,0x100,0x200,...], offsets_valid=1, one chunk addr 0x180 with payload lanes 0..7 = 0x0001..0x0008, ready high -> channel 1 emits 0x0001..0x0008 on consecutive cycles starting N+1; no other channel valid.
- CHUNK_DEPTH=2, channel 0 sample_tready=0, three chunks to channel 0 -> first two accepted; chunk_tready low on the third until channel 0 consumes 8 samples; data stays stable while stalled.
- Unmatched addr 0xFFFFF0, DROP_UNMATCHED=1 -> accepted in 1 cycle, drop_count 0->1, no sample output. With DROP_UNMATCHED=0 -> tready stays 0 indefinitely. With offsets_valid=0 -> every chunk is treated as unmatched.
- Channel 2 mid-chunk at idx=3, ch_flush[2] pulsed with a new channel-2 chunk accepted the same cycle -> next cycle emits the new chunk's lane 0; the old lanes 4..7 never appear.
- Overlapping bounds with off[1] < off[0] and an address in both ranges -> routed to the lowest valid matching index. Apply 70000 unmatched drops -> drop_count saturates at 0xFFFF.
- Assert rst_n asynchronously mid-stream -> outputs are zero or invalid immediately, queues are empty after release, and the first post-reset chunk is delivered correctly.

Source files
------------

// File: rtl/chunk_sample_router.sv
// Routes tagged DRAM read chunks to per-channel chunk queues by address range
// and serialises each queued chunk into a per-channel AXIS sample stream.
module chunk_sample_router #(
  parameter int CHANNELS       = 8,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 128,
  parameter int SAMPLE_W       = 16,
  parameter int CHUNK_DEPTH    = 2,
  parameter bit DROP_UNMATCHED = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [(CHANNELS+1)*ADDR_W-1:0] addr_offsets,
  input  logic                           offsets_valid,
  input  logic                           chunk_tvalid,
  output logic                           chunk_tready,
  input  logic [ADDR_W+DATA_W-1:0]       chunk_tdata,
  input  logic [CHANNELS-1:0]            ch_flush,
  output logic [CHANNELS-1:0]            sample_tvalid,
  input  logic [CHANNELS-1:0]            sample_tready,
  output logic [CHANNELS*SAMPLE_W-1:0]   sample_tdata,
  output logic [15:0]                    drop_count
);

  localparam int SPC  = DATA_W / SAMPLE_W;
  localparam int PW   = (CHUNK_DEPTH > 1) ? $clog2(CHUNK_DEPTH) : 1;
  localparam int CW   = $clog2(CHUNK_DEPTH + 1);
  localparam int IW   = (SPC > 1) ? $clog2(SPC) : 1;
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(CHUNK_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   payload;
  logic [CHANNELS-1:0] match;
  logic [CHANNELS-1:0] full;
  logic                hit;
  logic [SELW-1:0]     sel;
  logic                accept;
  logic                run;

  assign addr    = chunk_tdata[DATA_W +: ADDR_W];
  assign payload = chunk_tdata[DATA_W-1:0];

  // Decode: unsigned range compare, lowest matching channel wins
  for (genvar i = 0; i < CHANNELS; i++) begin : g_match
    assign match[i] = offsets_valid
                   && (addr >= addr_offsets[i*ADDR_W +: ADDR_W])
                   && (addr <  addr_offsets[(i+1)*ADDR_W +: ADDR_W]);
  end

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        sel = SELW'(i);
      end
    end
  end

  always_comb begin
    chunk_tready = 1'b0;
    if (run) begin
      if (hit) chunk_tready = !full[sel] || ch_flush[sel];
      else     chunk_tready = DROP_UNMATCHED;
    end
  end

  assign accept = chunk_tvalid && chunk_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      drop_count <= '0;
    end else begin
      run <= 1'b1;
      if (accept && !hit) drop_count <= sat_inc(drop_count);
    end
  end

  // Per-channel chunk queue and serialiser; output is read from queue storage
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DATA_W-1:0] mem [CHUNK_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] head;
    logic              push, hs, pop;

    assign push             = accept && hit && (sel == SELW'(i));
    assign sample_tvalid[i] = (count != '0);
    assign hs               = sample_tvalid[i] && sample_tready[i];
    assign pop              = hs && (idx == IW'(SPC - 1));
    assign full[i]          = (count == CW'(CHUNK_DEPTH));
    assign head             = mem[rptr];
    assign sample_tdata[i*SAMPLE_W +: SAMPLE_W] =
      sample_tvalid[i] ? head[int'(idx)*SAMPLE_W +: SAMPLE_W] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        idx   <= '0;
      end else if (ch_flush[i]) begin
        // flush empties first; a same-cycle push lands in slot 0
        rptr <= '0;
        idx  <= '0;
        if (push) begin
          wptr  <= ptr_inc('0);
          count <= CW'(1);
        end else begin
          wptr  <= '0;
          count <= '0;
        end
      end else begin
        if (push) wptr <= ptr_inc(wptr);
        if (pop)  rptr <= ptr_inc(rptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
        if (hs) idx <= pop ? '0 : idx + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[ch_flush[i] ? PW'(0) : wptr] <= payload;
    end
  end

endmodule

// File: tb/tb_chunk_sample_router.sv
// Scoreboard bench for chunk_sample_router: stimulus pushes expected samples
// per channel, a negedge monitor pops them on every output handshake.
module tb_chunk_sample_router;

  localparam int CH = 8;
  localparam int AW = 24;
  localparam int DW = 128;
  localparam int SW = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [(CH+1)*AW-1:0]  addr_offsets;
  logic                  offsets_valid;
  logic                  chunk_tvalid;
  logic                  chunk_tready;
  logic [AW+DW-1:0]      chunk_tdata;
  logic [CH-1:0]         ch_flush;
  logic [CH-1:0]         sample_tvalid;
  logic [CH-1:0]         sample_tready;
  logic [CH*SW-1:0]      sample_tdata;
  logic [15:0]           drop_count;

  logic                  stall_tvalid;
  logic                  stall_tready;
  logic [AW+DW-1:0]      stall_tdata;
  logic [CH-1:0]         stall_svalid;
  logic [CH*SW-1:0]      stall_sdata;
  logic [15:0]           stall_drops;
  logic [CH-1:0]         stall_flush = '0;
  logic [CH-1:0]         stall_sready = '1;

  int total = 0;
  int bad   = 0;
  logic [15:0] expq [CH][$];

  always #5 clk = ~clk;

  chunk_sample_router #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_W(SW),
                        .CHUNK_DEPTH(2), .DROP_UNMATCHED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .addr_offsets(addr_offsets), .offsets_valid(offsets_valid),
    .chunk_tvalid(chunk_tvalid), .chunk_tready(chunk_tready), .chunk_tdata(chunk_tdata),
    .ch_flush(ch_flush), .sample_tvalid(sample_tvalid), .sample_tready(sample_tready),
    .sample_tdata(sample_tdata), .drop_count(drop_count));

  chunk_sample_router #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_W(SW),
                        .CHUNK_DEPTH(2), .DROP_UNMATCHED(1'b0)) dut_stall (
    .clk(clk), .rst_n(rst_n), .addr_offsets(addr_offsets), .offsets_valid(offsets_valid),
    .chunk_tvalid(stall_tvalid), .chunk_tready(stall_tready), .chunk_tdata(stall_tdata),
    .ch_flush(stall_flush), .sample_tvalid(stall_svalid), .sample_tready(stall_sready),
    .sample_tdata(stall_sdata), .drop_count(stall_drops));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] lanes(input logic [15:0] base);
    logic [DW-1:0] p;
    for (int k = 0; k < DW/SW; k++) p[k*SW +: SW] = base + 16'(k);
    return p;
  endfunction

  task automatic push_exp(input int ch, input logic [DW-1:0] p);
    for (int k = 0; k < DW/SW; k++) expq[ch].push_back(p[k*SW +: SW]);
  endtask

  function automatic int qtotal();
    int n = 0;
    for (int c = 0; c < CH; c++) n += expq[c].size();
    return n;
  endfunction

  task automatic set_linear();
    for (int i = 0; i <= CH; i++) addr_offsets[i*AW +: AW] = AW'(i * 'h100);
  endtask

  task automatic wait_accept(output int waits);
    logic acc = 1'b0;
    waits = 0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = chunk_tready;
      @(posedge clk);
      #1;
      waits++;
    end
    chunk_tvalid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] p, output int waits);
    chunk_tdata  = {a, p};
    chunk_tvalid = 1'b1;
    wait_accept(waits);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((qtotal() != 0 || sample_tvalid != '0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(n < 100), 32'd1);
  endtask

  // Monitor: every output handshake must match the next expected sample
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rst_n && sample_tvalid[c] && sample_tready[c]) begin
        if (expq[c].size() == 0) begin
          chk($sformatf("unexpected_ch%0d", c), 32'(sample_tdata[c*SW +: SW]), 32'hDEAD_BEEF);
        end else begin
          chk($sformatf("sample_ch%0d", c), 32'(sample_tdata[c*SW +: SW]),
              32'(expq[c].pop_front()));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rdy_seen;
    rst_n = 1'b1;
    offsets_valid = 1'b1;
    chunk_tvalid = 1'b0;
    chunk_tdata = '0;
    ch_flush = '0;
    sample_tready = '1;
    stall_tvalid = 1'b0;
    stall_tdata = '0;
    set_linear();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tready", 32'(chunk_tready), 32'd0);
    chk("rst_tvalid", 32'(sample_tvalid), 32'd0);
    chk("rst_tdata_nonzero", 32'(sample_tdata != '0), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic routing: addr 0x180 -> channel 1, lanes 1..8, sample 0 next cycle
    send(24'h000180, lanes(16'h0001), w);
    push_exp(1, lanes(16'h0001));
    @(negedge clk);
    chk("t1_latency_valid", 32'(sample_tvalid), 32'h02);
    drain("t1_drain");

    // Back-pressure: channel 0 stalled, depth 2, third chunk must wait
    sample_tready[0] = 1'b0;
    send(24'h000010, lanes(16'h1001), w);
    chk("stall_c1_waits", 32'(w), 32'd1);
    push_exp(0, lanes(16'h1001));
    send(24'h000030, lanes(16'h1101), w);
    chk("stall_c2_waits", 32'(w), 32'd1);
    push_exp(0, lanes(16'h1101));
    chunk_tdata  = {24'h000040, lanes(16'h1201)};
    chunk_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_tready_low", 32'(chunk_tready), 32'd0);
      chk("stall_data_hold", 32'(sample_tdata[0 +: SW]), 32'h1001);
      chk("stall_valid_hold", 32'(sample_tvalid[0]), 32'd1);
    end
    @(posedge clk);
    #1 sample_tready[0] = 1'b1;
    wait_accept(w);
    chk("stall_c3_waits", 32'(w), 32'd9);
    push_exp(0, lanes(16'h1201));
    drain("stall_drain");

    // Flush mid-chunk with a same-cycle replacement chunk on channel 2
    send(24'h000210, lanes(16'h2001), w);
    push_exp(2, lanes(16'h2001));
    repeat (3) @(posedge clk);
    #1;
    chk("flush_idx3", 32'(sample_tdata[2*SW +: SW]), 32'h2004);
    sample_tready[2] = 1'b0;
    ch_flush[2] = 1'b1;
    expq[2].delete();
    send(24'h000280, lanes(16'h2101), w);
    ch_flush[2] = 1'b0;
    sample_tready[2] = 1'b1;
    chk("flush_accept_waits", 32'(w), 32'd1);
    push_exp(2, lanes(16'h2101));
    @(negedge clk);
    chk("flush_new_lane0", 32'(sample_tdata[2*SW +: SW]), 32'h2101);
    drain("flush_drain");

    // Overlapping ranges: 0x250 in channel 1 and channel 3, channel 1 wins
    addr_offsets[0*AW +: AW] = 24'h000100;
    addr_offsets[1*AW +: AW] = 24'h000080;
    addr_offsets[2*AW +: AW] = 24'h000300;
    addr_offsets[3*AW +: AW] = 24'h000200;
    send(24'h000250, lanes(16'h3001), w);
    push_exp(1, lanes(16'h3001));
    @(negedge clk);
    chk("overlap_route", 32'(sample_tvalid), 32'h02);
    drain("overlap_drain");
    set_linear();

    // Unmatched drop
    send(24'hFFFFF0, lanes(16'h6001), w);
    chk("drop_waits", 32'(w), 32'd1);
    @(negedge clk);
    chk("drop_count_1", 32'(drop_count), 32'd1);
    chk("drop_no_output", 32'(sample_tvalid), 32'd0);

    // Stall policy instance never accepts an unmatched chunk
    stall_tdata  = {24'hFFFFF0, lanes(16'h6101)};
    stall_tvalid = 1'b1;
    rdy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (stall_tready) rdy_seen++;
    end
    stall_tvalid = 1'b0;
    chk("nodrop_tready_cycles", 32'(rdy_seen), 32'd0);
    chk("nodrop_no_output", 32'(stall_svalid), 32'd0);
    @(posedge clk);
    #1;

    // Bounds invalid: in-range address is treated as unmatched
    offsets_valid = 1'b0;
    send(24'h000180, lanes(16'h7001), w);
    offsets_valid = 1'b1;
    chk("offinv_waits", 32'(w), 32'd1);
    @(negedge clk);
    chk("offinv_drops", 32'(drop_count), 32'd2);
    chk("offinv_no_output", 32'(sample_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // Drop counter saturation: one drop per cycle
    chunk_tdata  = {24'hFFFFF0, 128'h0};
    chunk_tvalid = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    chk("sat_mid", 32'(drop_count), 32'd1002);
    repeat (69000) @(posedge clk);
    #1;
    chunk_tvalid = 1'b0;
    chk("sat_final", 32'(drop_count), 32'hFFFF);

    // Asynchronous reset mid-stream
    send(24'h000410, lanes(16'h4001), w);
    push_exp(4, lanes(16'h4001));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int c = 0; c < CH; c++) expq[c].delete();
    #1;
    chk("arst_tvalid", 32'(sample_tvalid), 32'd0);
    chk("arst_tdata_nonzero", 32'(sample_tdata != '0), 32'd0);
    chk("arst_tready", 32'(chunk_tready), 32'd0);
    chk("arst_drops", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_queues_empty", 32'(sample_tvalid), 32'd0);
    @(posedge clk);
    #1;
    send(24'h000520, lanes(16'h5001), w);
    push_exp(5, lanes(16'h5001));
    @(negedge clk);
    chk("post_rst_valid", 32'(sample_tvalid), 32'h20);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
